// File: rtl/axis_resp_monitor_pkg.sv
// Shared types, error-bit indices and keep helpers for the KVS response monitor.
package axis_resp_monitor_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } state_e;

    localparam int unsigned ERR_W        = 4;
    localparam int unsigned ERR_ORPHAN   = 0;
    localparam int unsigned ERR_MIDKEEP  = 1;
    localparam int unsigned ERR_LASTKEEP = 2;
    localparam int unsigned ERR_OVF      = 3;

    // Widest tkeep the helper accepts; narrower keeps are zero-extended.
    localparam int unsigned KEEP_MAX_W = 64;

    // True when keep is a non-empty run of ones starting at byte 0 (2^n-1).
    function automatic logic keep_is_low_mask(input logic [KEEP_MAX_W-1:0] keep);
        return (keep != '0) && ((keep & (keep + KEEP_MAX_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/axis_resp_monitor_ts_fifo.sv
// Synchronous timestamp FIFO; push+pop together is legal even when full.
module ts_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             sys_rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (sys_rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axis_resp_monitor.sv
// Host-side sink for the KVS response stream: matches responses to requests,
// measures latency and flags protocol errors.
module axis_resp_monitor
    import axis_resp_monitor_pkg::*;
#(
    parameter int unsigned DATA_W     = 256,
    parameter int unsigned KEEP_W     = 32,
    parameter int unsigned USER_W     = 64,
    parameter int unsigned TS_W       = 64,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              sys_rst,
    input  logic              enable,
    input  logic              clear,
    input  logic              req_sent,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic [KEEP_W-1:0] s_tkeep,
    input  logic [USER_W-1:0] s_tuser,
    input  logic              s_tlast,
    input  logic              s_tvalid,
    output logic              s_tready,
    output logic [CNT_W-1:0]  nr_sent,
    output logic [CNT_W-1:0]  nr_received,
    output logic [CNT_W-1:0]  nr_beats,
    output logic              lat_valid,
    output logic [TS_W-1:0]   lat_last,
    output logic [TS_W-1:0]   lat_min,
    output logic [TS_W-1:0]   lat_max,
    output logic [TS_W-1:0]   lat_sum,
    output logic [ERR_W-1:0]  err,
    output logic              all_done
);

    state_e           state;
    state_e           state_nxt;
    logic [TS_W-1:0]  ts;
    logic [TS_W-1:0]  head_ts;
    logic [TS_W-1:0]  lat_now;
    logic [TS_W:0]    sum_ext;
    logic [ERR_W-1:0] err_set;
    logic             accept;
    logic             last_beat;
    logic             push_req;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic             overflow;
    logic             unused_inputs;

    assign unused_inputs = ^{s_tdata, s_tuser};

    assign accept    = s_tvalid && s_tready;
    assign last_beat = accept && s_tlast;
    assign push_req  = req_sent && enable;
    // Emptiness is judged before this cycle's push, so a same-cycle request cannot satisfy it.
    assign fifo_pop  = last_beat && !fifo_empty && !clear;
    assign overflow  = push_req && fifo_full && !fifo_pop;
    assign fifo_push = push_req && !overflow && !clear;
    assign lat_now   = ts - head_ts;
    assign sum_ext   = (TS_W+1)'(lat_sum) + (TS_W+1)'(lat_now);
    assign all_done  = (nr_sent == nr_received) && fifo_empty && (state == IDLE);

    always_comb begin
        err_set               = '0;
        err_set[ERR_ORPHAN]   = last_beat && fifo_empty;
        err_set[ERR_MIDKEEP]  = accept && !s_tlast && (s_tkeep != '1);
        err_set[ERR_LASTKEEP] = last_beat && !keep_is_low_mask(KEEP_MAX_W'(s_tkeep));
        err_set[ERR_OVF]      = overflow;
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else if (accept) begin
            state_nxt = s_tlast ? IDLE : IN_PKT;
        end
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state       <= IDLE;
            ts          <= '0;
            s_tready    <= 1'b0;
            nr_sent     <= '0;
            nr_received <= '0;
            nr_beats    <= '0;
            lat_valid   <= 1'b0;
            lat_last    <= '0;
            lat_min     <= '1;
            lat_max     <= '0;
            lat_sum     <= '0;
            err         <= '0;
        end else begin
            state     <= state_nxt;
            ts        <= ts + TS_W'(1);
            s_tready  <= enable;
            lat_valid <= 1'b0;
            if (clear) begin
                nr_sent     <= '0;
                nr_received <= '0;
                nr_beats    <= '0;
                lat_last    <= '0;
                lat_min     <= '1;
                lat_max     <= '0;
                lat_sum     <= '0;
                err         <= '0;
            end else begin
                if (push_req)  nr_sent     <= nr_sent + CNT_W'(1);
                if (accept)    nr_beats    <= nr_beats + CNT_W'(1);
                if (last_beat) nr_received <= nr_received + CNT_W'(1);
                if (fifo_pop) begin
                    lat_valid <= 1'b1;
                    lat_last  <= lat_now;
                    if (lat_now < lat_min) lat_min <= lat_now;
                    if (lat_now > lat_max) lat_max <= lat_now;
                    lat_sum <= sum_ext[TS_W] ? '1 : sum_ext[TS_W-1:0];
                end
                err <= err | err_set;
            end
        end
    end

    ts_fifo #(
        .WIDTH (TS_W),
        .DEPTH (FIFO_DEPTH)
    ) u_ts_fifo (
        .clk     (clk),
        .sys_rst (sys_rst),
        .flush   (clear),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .din     (ts),
        .dout    (head_ts),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_axis_resp_monitor.sv
// Directed bench for axis_resp_monitor: vector table plus hand-written corner sequences.
module tb_axis_resp_monitor;

    logic         clk = 1'b0;
    logic         sys_rst;
    logic         enable;
    logic         clear;
    logic         req_sent;
    logic [255:0] s_tdata;
    logic [31:0]  s_tkeep;
    logic [63:0]  s_tuser;
    logic         s_tlast;
    logic         s_tvalid;
    logic         s_tready;
    logic [31:0]  nr_sent;
    logic [31:0]  nr_received;
    logic [31:0]  nr_beats;
    logic         lat_valid;
    logic [63:0]  lat_last;
    logic [63:0]  lat_min;
    logic [63:0]  lat_max;
    logic [63:0]  lat_sum;
    logic [3:0]   err;
    logic         all_done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    localparam logic [31:0] KFULL = 32'hFFFF_FFFF;

    axis_resp_monitor dut (
        .clk         (clk),
        .sys_rst     (sys_rst),
        .enable      (enable),
        .clear       (clear),
        .req_sent    (req_sent),
        .s_tdata     (s_tdata),
        .s_tkeep     (s_tkeep),
        .s_tuser     (s_tuser),
        .s_tlast     (s_tlast),
        .s_tvalid    (s_tvalid),
        .s_tready    (s_tready),
        .nr_sent     (nr_sent),
        .nr_received (nr_received),
        .nr_beats    (nr_beats),
        .lat_valid   (lat_valid),
        .lat_last    (lat_last),
        .lat_min     (lat_min),
        .lat_max     (lat_max),
        .lat_sum     (lat_sum),
        .err         (err),
        .all_done    (all_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          req;
        bit          valid;
        bit          last;
        logic [31:0] keep;
        int          sent;
        int          rcv;
        int          beats;
        logic [3:0]  err;
        bit          lv;
        logic [63:0] lat;
        bit          done;
    } vec_t;

    vec_t vecs[6];

    // cyc tracks the DUT timestamp value during the cycle being driven.
    task automatic tick();
        @(posedge clk);
        if (sys_rst) cyc = 0;
        else         cyc++;
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic beat(input logic [31:0] keep, input bit last);
        s_tvalid = 1'b1;
        s_tkeep  = keep;
        s_tlast  = last;
        s_tdata  = {8{32'(cyc)}};
        tick();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        int pulses;

        // req, valid, last, keep, sent, rcv, beats, err, lat_valid, lat_last, all_done
        vecs[0] = '{0, 1, 1, KFULL,         0, 1, 1, 4'b0001, 0, 64'd0, 0};
        vecs[1] = '{0, 0, 0, KFULL,         0, 1, 1, 4'b0001, 0, 64'd0, 0};
        vecs[2] = '{1, 0, 0, KFULL,         1, 1, 1, 4'b0001, 0, 64'd0, 0};
        vecs[3] = '{0, 1, 0, 32'h0FFF_FFFF, 1, 1, 2, 4'b0011, 0, 64'd0, 0};
        vecs[4] = '{0, 1, 1, 32'h0000_00F0, 1, 2, 3, 4'b0111, 1, 64'd2, 0};
        vecs[5] = '{0, 0, 0, KFULL,         1, 2, 3, 4'b0111, 0, 64'd2, 0};

        sys_rst  = 1'b1;
        enable   = 1'b0;
        clear    = 1'b0;
        req_sent = 1'b0;
        s_tdata  = '0;
        s_tkeep  = KFULL;
        s_tuser  = '0;
        s_tlast  = 1'b0;
        s_tvalid = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_tready", 64'(s_tready), 64'd0);
        chk("rst_nr_sent", 64'(nr_sent), 64'd0);
        chk("rst_lat_min", lat_min, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rst_lat_max", lat_max, 64'd0);
        chk("rst_lat_sum", lat_sum, 64'd0);
        chk("rst_lat_valid", 64'(lat_valid), 64'd0);
        chk("rst_all_done", 64'(all_done), 64'd1);

        sys_rst = 1'b0;
        enable  = 1'b1;
        repeat (10) tick();
        chk("idle_tready", 64'(s_tready), 64'd1);
        chk("idle_counts", {nr_sent, nr_received}, 64'd0);
        chk("idle_beats", 64'(nr_beats), 64'd0);
        chk("idle_err", 64'(err), 64'd0);
        chk("idle_lat_min", lat_min, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("idle_all_done", 64'(all_done), 64'd1);

        // Request at ts=100, 3-beat response ending at ts=140
        while (cyc < 100) tick();
        req_sent = 1'b1;
        tick();
        req_sent = 1'b0;
        chk("m1_nr_sent", 64'(nr_sent), 64'd1);
        chk("m1_busy", 64'(all_done), 64'd0);
        while (cyc < 138) tick();
        beat(KFULL, 0);
        beat(KFULL, 0);
        beat(32'h0000_FFFF, 1);
        chk("m1_lat_valid", 64'(lat_valid), 64'd1);
        chk("m1_lat_last", lat_last, 64'd40);
        chk("m1_lat_min", lat_min, 64'd40);
        chk("m1_lat_max", lat_max, 64'd40);
        chk("m1_lat_sum", lat_sum, 64'd40);
        chk("m1_nr_received", 64'(nr_received), 64'd1);
        chk("m1_nr_beats", 64'(nr_beats), 64'd3);
        chk("m1_err", 64'(err), 64'd0);
        chk("m1_all_done", 64'(all_done), 64'd1);
        tick();
        chk("m1_lat_valid_pulse", 64'(lat_valid), 64'd0);

        // 17 requests into a 16-deep FIFO, then 16 responses
        do_clear();
        chk("clr_lat_sum", lat_sum, 64'd0);
        req_sent = 1'b1;
        repeat (17) tick();
        req_sent = 1'b0;
        chk("ovf_nr_sent", 64'(nr_sent), 64'd17);
        chk("ovf_err", 64'(err), 64'b1000);
        pulses = 0;
        s_tvalid = 1'b1;
        s_tlast  = 1'b1;
        s_tkeep  = KFULL;
        for (int j = 0; j < 16; j++) begin
            tick();
            if (lat_valid) pulses++;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        tick();
        if (lat_valid) pulses++;
        chk("ovf_pulses", 64'(pulses), 64'd16);
        chk("ovf_lat_min", lat_min, 64'd17);
        chk("ovf_lat_max", lat_max, 64'd17);
        chk("ovf_lat_sum", lat_sum, 64'd272);
        chk("ovf_nr_received", 64'(nr_received), 64'd16);
        chk("ovf_err_sticky", 64'(err), 64'b1000);
        chk("ovf_all_done", 64'(all_done), 64'd0);

        // Orphan and keep errors from the vector table
        do_clear();
        for (int i = 0; i < 6; i++) begin
            req_sent = vecs[i].req;
            s_tvalid = vecs[i].valid;
            s_tlast  = vecs[i].last;
            s_tkeep  = vecs[i].keep;
            tick();
            chk($sformatf("vec%0d_nr_sent", i), 64'(nr_sent), 64'(vecs[i].sent));
            chk($sformatf("vec%0d_nr_received", i), 64'(nr_received), 64'(vecs[i].rcv));
            chk($sformatf("vec%0d_nr_beats", i), 64'(nr_beats), 64'(vecs[i].beats));
            chk($sformatf("vec%0d_err", i), 64'(err), 64'(vecs[i].err));
            chk($sformatf("vec%0d_lat_valid", i), 64'(lat_valid), 64'(vecs[i].lv));
            chk($sformatf("vec%0d_lat_last", i), lat_last, vecs[i].lat);
            chk($sformatf("vec%0d_all_done", i), 64'(all_done), 64'(vecs[i].done));
        end
        req_sent = 1'b0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;

        // Push and pop together with one entry held
        do_clear();
        req_sent = 1'b1;
        tick();
        req_sent = 1'b0;
        repeat (4) tick();
        req_sent = 1'b1;
        beat(KFULL, 1);
        req_sent = 1'b0;
        chk("pp1_lat_valid", 64'(lat_valid), 64'd1);
        chk("pp1_lat_last", lat_last, 64'd5);
        chk("pp1_nr_sent", 64'(nr_sent), 64'd2);
        chk("pp1_err", 64'(err), 64'd0);
        chk("pp1_all_done", 64'(all_done), 64'd0);
        beat(KFULL, 1);
        chk("pp1_second_lat", lat_last, 64'd1);
        chk("pp1_drained", 64'(all_done), 64'd1);

        // Push and pop together with the FIFO empty
        do_clear();
        req_sent = 1'b1;
        beat(KFULL, 1);
        req_sent = 1'b0;
        chk("pp0_err", 64'(err), 64'b0001);
        chk("pp0_lat_valid", 64'(lat_valid), 64'd0);
        chk("pp0_nr_received", 64'(nr_received), 64'd1);
        repeat (2) tick();
        beat(KFULL, 1);
        chk("pp0_retained_lv", 64'(lat_valid), 64'd1);
        chk("pp0_retained_lat", lat_last, 64'd3);

        // Clear after beat 2 of 4
        do_clear();
        req_sent = 1'b1;
        tick();
        req_sent = 1'b0;
        beat(KFULL, 0);
        beat(KFULL, 0);
        do_clear();
        chk("clrmid_beats", 64'(nr_beats), 64'd0);
        chk("clrmid_sent", 64'(nr_sent), 64'd0);
        chk("clrmid_all_done", 64'(all_done), 64'd1);
        beat(KFULL, 0);
        beat(KFULL, 1);
        chk("clrmid_rest_beats", 64'(nr_beats), 64'd2);
        chk("clrmid_rest_rcv", 64'(nr_received), 64'd1);
        chk("clrmid_rest_err", 64'(err), 64'b0001);
        chk("clrmid_rest_lv", 64'(lat_valid), 64'd0);

        // Enable dropped mid-packet holds state and backpressures
        do_clear();
        beat(KFULL, 0);
        chk("en_in_pkt", 64'(all_done), 64'd0);
        enable = 1'b0;
        tick();
        chk("en_tready_low", 64'(s_tready), 64'd0);
        s_tvalid = 1'b1;
        s_tlast  = 1'b1;
        s_tkeep  = KFULL;
        repeat (2) tick();
        chk("en_held_beats", 64'(nr_beats), 64'd1);
        chk("en_held_state", 64'(all_done), 64'd0);
        enable = 1'b1;
        tick();
        chk("en_reready_beats", 64'(nr_beats), 64'd1);
        tick();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        chk("en_resume_beats", 64'(nr_beats), 64'd2);
        chk("en_resume_rcv", 64'(nr_received), 64'd1);
        chk("en_resume_err", 64'(err), 64'b0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
